// File: rtl/apb_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_arbiter
//
// Round-robin front end that lets two requesters share one APB master.
// A requester raises req[i] with its command fields held stable. The arbiter
// picks an owner, latches that owner's command into the master command
// registers and pulses transfer for one cycle. It then watches the bus phase
// signals until the access completes, or until the WAIT-state limit forces a
// timeout. Finally it returns done/rdata/error/tmo to the owner.
//
// Parameter
//   TIMEOUT     WAIT-state cycle limit before forced completion (2..255)
//
// Ports
//   PCLK        clock, rising edge
//   PRESET      asynchronous active-high reset
//   req[1:0]    request level per requester
//   req_write   per-requester direction (1 = write)
//   req_addr    per-requester address, [31:0] req0, [63:32] req1
//   req_wdata   per-requester write data, packed as req_addr
//   req_strb    per-requester byte strobes, [3:0] req0, [7:4] req1
//   req_prot    per-requester protection, [2:0] req0, [5:3] req1
//   req_pnse    per-requester PNSE bit
//   gnt         one-hot owner of the current transaction, 0 when idle
//   done        one-cycle completion pulse to the owner
//   rdata       read data returned with done (0 for writes and timeouts)
//   error       slave error or timeout, valid with done
//   tmo         timeout flag, valid with done
//   transfer    one-cycle start pulse to the APB master
//   write_en, waddr, wdata, strb, prot, pnse
//               registered master command fields
//   PSELx, PENABLE, PREADY, PSLVERR, PRDATA
//               bus phase monitors and read data
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending requests
// ISSUE | command registers loaded; pulse transfer, clear WAIT counter
// WAIT  | waiting for PSELx & PENABLE & PREADY or the WAIT-state limit
// DONE  | pulse done to the owner, hand priority to the other requester
// ---------------------------------------------------------------------------
module apb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  req,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strb,
    input  logic [5:0]  req_prot,
    input  logic [1:0]  req_pnse,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        error,
    output logic        tmo,
    output logic        transfer,
    output logic        write_en,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  strb,
    output logic [2:0]  prot,
    output logic        pnse,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The counter starts at 0 in the first WAIT cycle; the access is abandoned
    // at the edge where it would step to TIMEOUT-1, i.e. after TIMEOUT-1 WAIT
    // cycles without completion.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic        ptr;
    logic [1:0]  win;
    logic        bus_done;
    logic        cnt_last;

    assign bus_done = PSELx & PENABLE & PREADY;
    assign cnt_last = (cnt == CNT_LAST);

    // Round-robin pick: ptr only matters when both requesters are pending.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion and the limit may coincide; both leave for DONE,
                // the datapath below gives completion priority.
                if (bus_done || cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        transfer = 1'b0;
        done     = 2'b00;
        case (state)
            ST_ISSUE: transfer = 1'b1;
            ST_DONE:  done     = gnt;
            default: begin
                transfer = 1'b0;
                done     = 2'b00;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Owner, command registers, WAIT counter, priority pointer and response
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            gnt      <= 2'b00;
            ptr      <= 1'b0;
            cnt      <= 8'd0;
            rdata    <= 32'd0;
            error    <= 1'b0;
            tmo      <= 1'b0;
            write_en <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
            strb     <= 4'd0;
            prot     <= 3'd0;
            pnse     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt <= win;
                        if (win[1]) begin
                            write_en <= req_write[1];
                            waddr    <= req_addr[63:32];
                            wdata    <= req_wdata[63:32];
                            strb     <= req_strb[7:4];
                            prot     <= req_prot[5:3];
                            pnse     <= req_pnse[1];
                        end else begin
                            write_en <= req_write[0];
                            waddr    <= req_addr[31:0];
                            wdata    <= req_wdata[31:0];
                            strb     <= req_strb[3:0];
                            prot     <= req_prot[2:0];
                            pnse     <= req_pnse[0];
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt <= 8'd0;
                end
                ST_WAIT: begin
                    if (bus_done) begin
                        rdata <= write_en ? 32'd0 : PRDATA;
                        error <= PSLVERR;
                        tmo   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt_last) begin
                            rdata <= 32'd0;
                            error <= 1'b1;
                            tmo   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Priority passes to whoever did not own this transaction.
                    ptr <= gnt[0];
                    gnt <= 2'b00;
                end
                default: begin
                    gnt <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
`timescale 1ns/1ps
module tb_apb_arbiter;

    localparam int TMO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strb = '0;
    logic [5:0]  req_prot = '0;
    logic [1:0]  req_pnse = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        error;
    logic        tmo;
    logic        transfer;
    logic        write_en;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        pnse;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;

    apb_arbiter #(.TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .req_pnse(req_pnse),
        .gnt(gnt), .done(done), .rdata(rdata), .error(error), .tmo(tmo),
        .transfer(transfer), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .strb(strb), .prot(prot), .pnse(pnse),
        .PSELx(PSELx), .PENABLE(PENABLE), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        pnse;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail = 0;

    // requester model
    logic [1:0]  pend = '0;
    logic        wr_m   [2];
    logic [31:0] addr_m [2];
    logic [31:0] wd_m   [2];
    logic [3:0]  strb_m [2];
    logic [2:0]  prot_m [2];
    logic        pnse_m [2];
    int          prefer = 0;   // requester served when both pend; the one not served last
    bit          allow_late = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_tmo"}, tmo, 0);
        chk({tag, "_transfer"}, transfer, 0);
        chk({tag, "_write_en"}, write_en, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_strb"}, strb, 0);
        chk({tag, "_prot"}, prot, 0);
        chk({tag, "_pnse"}, pnse, 0);
    endtask

    task automatic drive_reqs();
        req       = pend;
        req_write = {wr_m[1], wr_m[0]};
        req_addr  = {addr_m[1], addr_m[0]};
        req_wdata = {wd_m[1], wd_m[0]};
        req_strb  = {strb_m[1], strb_m[0]};
        req_prot  = {prot_m[1], prot_m[0]};
        req_pnse  = {pnse_m[1], pnse_m[0]};
    endtask

    task automatic raise(input int i);
        pend[i]   = 1'b1;
        wr_m[i]   = 1'($urandom_range(0, 1));
        addr_m[i] = $urandom;
        wd_m[i]   = $urandom;
        strb_m[i] = 4'($urandom_range(0, 15));
        prot_m[i] = 3'($urandom_range(0, 7));
        pnse_m[i] = 1'($urandom_range(0, 1));
    endtask

    function automatic int pick_k();
        case ($urandom_range(0, 7))
            0:       return 1;
            1:       return TMO - 1;
            2:       return TMO;
            3:       return TMO + 4;
            default: return $urandom_range(2, 6);
        endcase
    endfunction

    // Called at a negedge while the DUT is idle. k = WAIT cycle in which the
    // slave completes; k > TMO-1 means it never completes in time.
    task automatic txn(input logic [1:0] newreq, input int k, input bit abort,
                       input int slv_mode, input bit prd_fixed, input logic [31:0] prd_val);
        int o;
        int nw;
        int w;
        bit comp;
        logic [31:0] prd;
        logic slv;
        exp_t e;
        for (int i = 0; i < 2; i++)
            if (newreq[i] && !pend[i]) raise(i);
        if (pend == 2'b00) raise($urandom_range(0, 1));
        drive_reqs();
        o    = (pend == 2'b11) ? prefer : (pend[1] ? 1 : 0);
        comp = (k <= TMO - 1);
        nw   = comp ? k : TMO - 1;
        prd  = prd_fixed ? prd_val : $urandom;
        slv  = (slv_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(slv_mode);
        e.gnt   = (o == 1) ? 2'b10 : 2'b01;
        e.wr    = wr_m[o];
        e.addr  = addr_m[o];
        e.wdata = wd_m[o];
        e.strb  = strb_m[o];
        e.prot  = prot_m[o];
        e.pnse  = pnse_m[o];
        e.rdata = (comp && !wr_m[o]) ? prd : 32'd0;
        e.err   = comp ? slv : 1'b1;
        e.tmo   = !comp;
        e.cyc   = cyc + 2 + nw;
        if (!abort) sbq.push_back(e);

        @(negedge PCLK);                       // ISSUE cycle
        chk("transfer_latency", transfer, 1);
        chk("gnt_at_issue", gnt, e.gnt);
        @(negedge PCLK);                       // WAIT cycle 1
        chk("transfer_one_cycle", transfer, 0);
        for (int j = 1; j <= nw; j++) begin
            PSELx   = 1'b1;
            PENABLE = (j >= 2) || (k == 1);
            if (j == k)        PREADY = 1'b1;
            else if (PENABLE)  PREADY = 1'b0;
            else               PREADY = 1'($urandom_range(0, 1));
            PRDATA  = (j == k) ? prd : $urandom;
            PSLVERR = (j == k) ? slv : 1'($urandom_range(0, 1));
            if (j == 1 && allow_late && !pend[1 - o] && $urandom_range(0, 1) == 1) begin
                raise(1 - o);
                drive_reqs();
            end
            if (abort && j == 3) begin
                #2 PRESET = 1'b1;
                #1 check_zero("abort");
                @(negedge PCLK);
                PRESET  = 1'b0;
                pend    = 2'b00;
                drive_reqs();
                PSELx   = 1'b0;
                PENABLE = 1'b0;
                PREADY  = 1'b0;
                prefer  = 0;
                @(negedge PCLK);
                return;
            end
            @(negedge PCLK);
        end
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PREADY  = 1'b0;
        w = 0;
        while (done === 2'b00 && w < 40) begin
            @(negedge PCLK);
            w++;
        end
        if (w >= 40) chk("done_wait_expired", done, e.gnt);
        @(posedge PCLK);
        #1;
        pend[o] = 1'b0;
        prefer  = 1 - o;
        drive_reqs();
        @(negedge PCLK);                       // mandatory IDLE cycle
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge PCLK);
            if (done !== 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_owner", done, mon_e.gnt);
                    chk("gnt_in_done", gnt, mon_e.gnt);
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk("rdata", rdata, mon_e.rdata);
                    chk("error", error, mon_e.err);
                    chk("tmo", tmo, mon_e.tmo);
                    chk("write_en", write_en, mon_e.wr);
                    chk("waddr", waddr, mon_e.addr);
                    chk("wdata", wdata, mon_e.wdata);
                    chk("strb", strb, mon_e.strb);
                    chk("prot", prot, mon_e.prot);
                    chk("pnse", pnse, mon_e.pnse);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr_m[i] = 0; addr_m[i] = 0; wd_m[i] = 0;
            strb_m[i] = 0; prot_m[i] = 0; pnse_m[i] = 0;
        end
        repeat (3) @(negedge PCLK);
        check_zero("reset");
        PRESET = 1'b0;
        @(negedge PCLK);
        check_zero("after_release");

        // write from req0, immediate ready
        pend[0] = 1'b1; wr_m[0] = 1'b1; addr_m[0] = 32'h0; wd_m[0] = 32'hDEADBEEF;
        strb_m[0] = 4'hF; prot_m[0] = 3'd0; pnse_m[0] = 1'b0;
        txn(2'b00, 1, 0, 0, 0, 32'd0);
        // read from req1 with slave error
        pend[1] = 1'b1; wr_m[1] = 1'b0; addr_m[1] = 32'h4; wd_m[1] = 32'h0;
        strb_m[1] = 4'h0; prot_m[1] = 3'd2; pnse_m[1] = 1'b1;
        txn(2'b00, 2, 0, 1, 1, 32'hABCDABCD);
        // timeout
        txn(2'b01, TMO + 3, 0, 0, 0, 32'd0);
        // completion on the limit cycle
        txn(2'b10, TMO - 1, 0, 1, 0, 32'd0);
        txn(2'b10, TMO - 1, 0, 0, 0, 32'd0);
        // both held: strict alternation
        repeat (4) txn(2'b11, 2, 0, 2, 0, 32'd0);
        while (pend != 2'b00) txn(2'b00, 2, 0, 2, 0, 32'd0);

        allow_late = 1;
        for (int n = 0; n < 150; n++) begin
            if (pend == 2'b00 && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge PCLK);
            txn(2'($urandom_range(0, 3)), pick_k(), 0, 2, 0, 32'd0);
        end
        allow_late = 0;
        while (pend != 2'b00) txn(2'b00, 2, 0, 2, 0, 32'd0);

        // leave priority with req1, then abort a transaction with reset
        txn(2'b01, 2, 0, 2, 0, 32'd0);
        txn(2'b10, TMO + 10, 1, 2, 0, 32'd0);
        txn(2'b11, 3, 0, 2, 0, 32'd0);
        txn(2'b00, 3, 0, 2, 0, 32'd0);
        txn(2'b10, 2, 0, 2, 0, 32'd0);

        repeat (3) @(negedge PCLK);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
